// File: rtl/huffman_dec.sv
// huffman_dec: serial Huffman decoder for the 6-symbol gray-level image path.
//
// A code table (HC1..HC6 code bits, M1..M6 length masks) is latched on a
// code_valid pulse. After that, a root-first serial bitstream is consumed one
// bit per accepted cycle. Each completed codeword emits one gray value
// (8'h01..8'h06) on sym_data with a one-cycle sym_valid pulse. Eight
// accumulated bits with no match raise a one-cycle err pulse.
//
// Ports:
//   clk         clock, all state on rising edge
//   reset       asynchronous, active-high
//   code_valid  one-cycle pulse, HC1..HC6 / M1..M6 valid (loads or reloads the table)
//   HC1..HC6    code bits, HCk[L-1] transmitted first
//   M1..M6      contiguous low-ones length masks, 0 disables the symbol
//   bit_valid   serial bit qualifier
//   bit_in      serial code bit
//   bit_ready   high once a table is loaded
//   sym_valid   one-cycle pulse, decoded symbol on sym_data
//   sym_data    decoded gray value, holds between pulses
//   err         one-cycle pulse, 8 bits without a match
//   sym_cnt     saturating count of symbols since the last table load
module huffman_dec (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        bit_ready,
  output logic        sym_valid,
  output logic [7:0]  sym_data,
  output logic        err,
  output logic [15:0] sym_cnt
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic        state_q, state_d;
  logic [7:0]  hc_q [6];
  logic [7:0]  hc_d [6];
  logic [3:0]  lk_q [6];
  logic [3:0]  lk_d [6];
  logic [7:0]  acc_q, acc_d;
  logic [3:0]  len_q, len_d;
  logic        sym_valid_q, sym_valid_d;
  logic [7:0]  sym_data_q, sym_data_d;
  logic        err_q, err_d;
  logic [15:0] sym_cnt_q, sym_cnt_d;

  logic [7:0]  hc_in [6];
  logic [7:0]  m_in  [6];
  logic        accept;
  logic [7:0]  nacc;
  logic [3:0]  nlen;
  logic [5:0]  hit;
  logic        match_found;
  logic [2:0]  match_idx;

  assign hc_in[0] = HC1;
  assign hc_in[1] = HC2;
  assign hc_in[2] = HC3;
  assign hc_in[3] = HC4;
  assign hc_in[4] = HC5;
  assign hc_in[5] = HC6;
  assign m_in[0]  = M1;
  assign m_in[1]  = M2;
  assign m_in[2]  = M3;
  assign m_in[3]  = M4;
  assign m_in[4]  = M5;
  assign m_in[5]  = M6;

  // Code length from a contiguous low-ones mask.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Low-ones mask covering the last l accumulated bits (l = 8 gives 8'hFF).
  function automatic logic [7:0] len_mask(input logic [3:0] l);
    logic [7:0] shifted;
    shifted = 8'hFF << l;
    return ~shifted;
  endfunction

  // code_valid takes priority, so a bit arriving with it is dropped.
  assign accept = (state_q == ST_RUN) & bit_valid & ~code_valid;
  assign nacc   = {acc_q[6:0], bit_in};
  assign nlen   = len_q + 4'd1;

  // Per-symbol match against the candidate accumulator. The lowest index wins.
  always_comb begin
    hit       = 6'b000000;
    match_idx = 3'd0;
    for (int k = 0; k < 6; k++) begin
      hit[k] = (lk_q[k] != 4'd0) && (nlen == lk_q[k]) &&
               ((nacc & len_mask(lk_q[k])) == hc_q[k]);
    end
    // Scan from the top down so the lowest hitting index is the last written.
    for (int k = 5; k >= 0; k--) begin
      match_idx = hit[k] ? 3'(k + 1) : match_idx;
    end
    match_found = |hit;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the only exit from IDLE is a table load. RUN is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (code_valid) state_d = ST_RUN;
        else            state_d = ST_IDLE;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values: table load, bit accumulate, match or error.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      hc_d[k] = hc_q[k];
      lk_d[k] = lk_q[k];
    end
    acc_d       = acc_q;
    len_d       = len_q;
    sym_valid_d = 1'b0;
    sym_data_d  = sym_data_q;
    err_d       = 1'b0;
    sym_cnt_d   = sym_cnt_q;
    if (code_valid) begin
      for (int k = 0; k < 6; k++) begin
        hc_d[k] = hc_in[k] & m_in[k];
        lk_d[k] = popcount8(m_in[k]);
      end
      acc_d     = 8'h00;
      len_d     = 4'd0;
      sym_cnt_d = 16'h0000;
    end else if (accept) begin
      if (match_found) begin
        sym_valid_d = 1'b1;
        sym_data_d  = {5'b00000, match_idx};
        sym_cnt_d   = (sym_cnt_q == 16'hFFFF) ? sym_cnt_q : sym_cnt_q + 16'd1;
        acc_d       = 8'h00;
        len_d       = 4'd0;
      end else if (nlen == 4'd8) begin
        err_d = 1'b1;
        acc_d = 8'h00;
        len_d = 4'd0;
      end else begin
        acc_d = nacc;
        len_d = nlen;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) begin
        hc_q[k] <= 8'h00;
        lk_q[k] <= 4'd0;
      end
      acc_q       <= 8'h00;
      len_q       <= 4'd0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= 8'h00;
      err_q       <= 1'b0;
      sym_cnt_q   <= 16'h0000;
    end else begin
      for (int k = 0; k < 6; k++) begin
        hc_q[k] <= hc_d[k];
        lk_q[k] <= lk_d[k];
      end
      acc_q       <= acc_d;
      len_q       <= len_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      err_q       <= err_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  assign bit_ready = (state_q == ST_RUN);
  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign err       = err_q;
  assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_huffman_dec.sv
// tb_huffman_dec: randomized and directed self-checking bench for huffman_dec.
// The reference model keeps the partial codeword as a queue of bits and checks
// it against each table entry in symbol order.
module tb_huffman_dec;

  logic        clk = 1'b0;
  logic        reset;
  logic        code_valid;
  logic [7:0]  hc_in [6];
  logic [7:0]  m_in  [6];
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        sym_valid;
  logic [7:0]  sym_data;
  logic        err;
  logic [15:0] sym_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit  m_run;
  int  m_hc  [6];
  int  m_len [6];
  bit  m_q   [$];
  int  m_cnt;
  bit  m_sv;
  int  m_sd;
  bit  m_err;

  always #5 clk = ~clk;

  huffman_dec dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc_in[0]), .HC2(hc_in[1]), .HC3(hc_in[2]),
    .HC4(hc_in[3]), .HC5(hc_in[4]), .HC6(hc_in[5]),
    .M1(m_in[0]), .M2(m_in[1]), .M3(m_in[2]),
    .M4(m_in[3]), .M5(m_in[4]), .M6(m_in[5]),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .sym_valid(sym_valid), .sym_data(sym_data),
    .err(err), .sym_cnt(sym_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 1'b0;
    m_q.delete();
    m_cnt = 0;
    m_sv  = 1'b0;
    m_sd  = 0;
    m_err = 1'b0;
    for (int k = 0; k < 6; k++) begin
      m_hc[k]  = 0;
      m_len[k] = 0;
    end
  endfunction

  // One rising edge of the reference, using the inputs held across that edge.
  function automatic void model_clock();
    int  v;
    bit  found;
    m_sv  = 1'b0;
    m_err = 1'b0;
    if (code_valid) begin
      for (int k = 0; k < 6; k++) begin
        m_len[k] = $countones(m_in[k]);
        m_hc[k]  = int'(hc_in[k] & m_in[k]);
      end
      m_q.delete();
      m_cnt = 0;
      m_run = 1'b1;
    end else if (m_run && bit_valid) begin
      m_q.push_back(bit_in);
      v = 0;
      foreach (m_q[i]) v = (v << 1) | int'(m_q[i]);
      found = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (!found && m_len[k] != 0 && m_len[k] == m_q.size() && v == m_hc[k]) begin
          found = 1'b1;
          m_sv  = 1'b1;
          m_sd  = k + 1;
          if (m_cnt < 65535) m_cnt++;
          m_q.delete();
        end
      end
      if (!found && m_q.size() == 8) begin
        m_err = 1'b1;
        m_q.delete();
      end
    end
  endfunction

  task automatic check_all();
    check("bit_ready", {31'd0, bit_ready}, {31'd0, m_run});
    check("sym_valid", {31'd0, sym_valid}, {31'd0, m_sv});
    check("sym_data",  {24'd0, sym_data}, m_sd);
    check("err",       {31'd0, err},      {31'd0, m_err});
    check("sym_cnt",   {16'd0, sym_cnt},  m_cnt);
  endtask

  // Apply one cycle of inputs, clock it, and compare one ns after the edge.
  task automatic cycle(input bit cv, input bit bv, input bit b);
    code_valid = cv;
    bit_valid  = bv;
    bit_in     = b;
    @(posedge clk);
    model_clock();
    #1;
    check_all();
    code_valid = 1'b0;
    bit_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    check_all();
    reset = 1'b0;
  endtask

  task automatic set_table_t(input bit m6_off);
    for (int k = 0; k < 5; k++) begin
      hc_in[k] = 8'h01;
      m_in[k]  = 8'((1 << (k + 1)) - 1);
    end
    hc_in[5] = 8'h00;
    m_in[5]  = m6_off ? 8'h00 : 8'h1F;
  endtask

  // Send the table-T code of symbol k (1..6), first transmitted bit first.
  task automatic send_code_t(input int k);
    int l;
    l = (k == 6) ? 5 : k;
    for (int i = l - 1; i >= 0; i--) begin
      cycle(1'b0, 1'b1, (k != 6) && (i == 0));
    end
  endtask

  initial begin
    reset      = 1'b1;
    code_valid = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    for (int k = 0; k < 6; k++) begin
      hc_in[k] = 8'h00;
      m_in[k]  = 8'h00;
    end
    model_reset();
    #12;
    check_all();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // No table loaded: bits are ignored
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1);
    check("idle_cnt", {16'd0, sym_cnt}, 32'd0);

    // All six codes back-to-back
    set_table_t(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) send_code_t(k);
    check("six_cnt", {16'd0, sym_cnt}, 32'd6);
    check("six_last", {24'd0, sym_data}, 32'd6);

    // Length-1 code on consecutive bits
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1);
    check("rep_cnt", {16'd0, sym_cnt}, 32'd4);

    // Eight zeros with symbol 6 disabled, then a 1
    set_table_t(1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    check("err_pulse", {31'd0, err}, 32'd1);
    cycle(1'b0, 1'b1, 1'b1);
    check("after_err", {24'd0, sym_data}, 32'd1);

    // Reload during a partial code, with a simultaneous bit that must be dropped
    set_table_t(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check("drop_sv", {31'd0, sym_valid}, 32'd0);
    cycle(1'b0, 1'b1, 1'b1);
    check("reload_cnt", {16'd0, sym_cnt}, 32'd1);

    // Reset mid-stream, then reload
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    do_reset();
    check("rst_ready", {31'd0, bit_ready}, 32'd0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    check("rst_reload", {24'd0, sym_data}, 32'd1);

    // Random tables and streams with gaps, reloads and resets
    for (int it = 0; it < 24; it++) begin
      if (it % 8 == 7) begin
        @(negedge clk);
        do_reset();
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 6; k++) begin
        int l;
        l        = (($urandom % 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 8);
        m_in[k]  = 8'((1 << l) - 1);
        hc_in[k] = 8'($urandom);
      end
      cycle(1'b1, 1'($urandom), 1'($urandom));
      for (int c = 0; c < 120; c++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 2)       cycle(1'b1, 1'($urandom), 1'($urandom));
        else if (r < 72) cycle(1'b0, 1'b1, 1'($urandom));
        else             cycle(1'b0, 1'b0, 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/huffman_dec.md
# huffman_dec

Serial Huffman decoder for the 6-symbol gray-level image path. It latches the code table produced by the encoder stage (HC1..HC6 codes and M1..M6 masks, qualified by `code_valid`). It then consumes a root-first serial bitstream and emits one decoded gray value (8'h01..8'h06) per completed codeword, plus a running symbol count and an error flag for invalid bit sequences.

## Interface
- No parameters.
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- code_valid  input  1  one-cycle pulse; HC1..HC6/M1..M6 valid this cycle
- HC1..HC6  input  8 each  code bits; HCk[L-1] is the root-side (first transmitted) bit, HCk[0] the last
- M1..M6  input  8 each  length masks, contiguous low ones (2^L-1); M=0 disables the symbol
- bit_valid  input  1  serial bit qualifier
- bit_in  input  1  serial code bit
- bit_ready  output  1  high in RUN; bits are accepted only when bit_valid & bit_ready
- sym_valid  output  1  one-cycle pulse, decoded symbol on sym_data
- sym_data  output  8  decoded gray value 8'h01..8'h06
- err  output  1  one-cycle pulse, 8 bits accumulated without a match
- sym_cnt  output  16  total symbols decoded since the last table load

## Operation
- States: IDLE (no table) and RUN.
- Reset: all outputs 0. State IDLE. Table, accumulator `acc[7:0]` and length `len[3:0]` are cleared.
- IDLE: bit_ready=0, bit_valid ignored. When code_valid=1: latch HCk masked by Mk, latch Lk = popcount(Mk), clear acc/len/sym_cnt, go to RUN.
- RUN, accepted bit: nacc={acc[6:0],bit_in}, nlen=len+1.
  - Symbol k matches when Lk!=0, nlen==Lk, and nacc[Lk-1:0]==HCk[Lk-1:0].
  - Prefix-free table means at most one match. If several match, the lowest k wins.
  - On match: sym_valid=1, sym_data=k, sym_cnt+=1, acc/len cleared.
  - No match and nlen==8: err=1, acc/len cleared, no symbol.
  - Otherwise: acc<=nacc, len<=nlen.
- RUN with code_valid=1: reload the table and clear acc/len/sym_cnt. A partial codeword is discarded. code_valid wins over a simultaneous bit_valid; that bit is dropped, with no sym_valid and no err.
- sym_cnt saturates at 16'hFFFF. sym_data holds its last value between pulses.
- RUN is left only by reset. bit_valid gaps of any length are allowed, and a partial code persists across gaps.

## Timing
- Throughput one bit per cycle, no stall. bit_ready is constant 1 in RUN.
- Bit accepted at edge N. If it completes a codeword, sym_valid/sym_data/sym_cnt are registered at edge N and visible in cycle N+1, i.e. 1-cycle latency.
- Back-to-back codewords: a length-1 code repeated on consecutive bits gives sym_valid high on consecutive cycles.
- code_valid at edge N: bit_ready=1 from cycle N+1, and the first bit is accepted at edge N+1.
- err is registered at the edge that accepts the 8th unmatched bit.
- Reset asserted mid-stream: immediate return to IDLE, outputs 0, table lost. A new code_valid is required before decoding resumes.

## Test plan
Test table T: HC1..HC5=8'h01, HC6=8'h00; M1=01, M2=03, M3=07, M4=0F, M5=1F, M6=1F. Codes: 1, 01, 001, 0001, 00001, 00000.

- Reset, no code_valid, bit_valid=1 with bit_in=1 for 10 cycles -> bit_ready=0, sym_valid never asserted, sym_cnt=0.
- Load T, then stream 1,01,001,0001,00001,00000 back-to-back -> sym_data 01,02,03,04,05,06. Each sym_valid appears one cycle after the codeword's last bit; sym_cnt=6.
- Load T, bit_in=1 for 4 consecutive cycles -> sym_valid high 4 consecutive cycles, sym_data=01, sym_cnt=4.
- Load T with M6=0, then stream 00000,0,0,0 (8 zeros) -> no symbol; err pulses one cycle after the 8th bit. Next bit 1 decodes 01.
- Load T, send 0,0, then code_valid together with bit_valid (bit 1), then send 1 -> the partial 00 is discarded, the simultaneous bit is dropped, the following 1 decodes 01, and sym_cnt=1.
- Load T, send 0,0, assert reset for one cycle -> all outputs 0 and bit_ready=0. Reload T and send 1 -> sym_data=01.
